sr_cmd_conditioner: RTL and testbench

//  Upstream stage for the SR latch. Conditions two raw, asynchronous, bouncy

---
 rtl/sr_cmd_conditioner.sv | 228 ++++++++++++++++++++++
 tb/tb_sr_cmd_conditioner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_conditioner.sv
// -----------------------------------------------------------------------------
// sr_cmd_conditioner
//
// Front end for an SR latch. Takes two raw, asynchronous, bouncy push-button
// inputs (set and clear) and turns each accepted press into exactly one
// fixed-width, registered set or clear command for the latch.
//
// Datapath per channel:
//   two-flop synchroniser -> debounce counter -> rising-edge detector
// followed by a shared IDLE/SET/CLR/GAP command FSM.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synced cycles needed to accept a
//                     change on an input (>= 1)
//   PULSE_LEN       : cycles that s or r (together with en) stay high for
//                     each command (>= 1)
//
// Ports
//   clk          in   rising-edge clock for every flop
//   rst          in   asynchronous, active-low reset
//   set_btn      in   raw set request (asynchronous, bouncy)
//   clr_btn      in   raw clear request (asynchronous, bouncy)
//   s            out  registered set command to the latch
//   r            out  registered reset command to the latch
//   en           out  registered latch enable, equal to s | r
//   busy         out  high whenever the FSM is not in IDLE
//   conflict     out  one-cycle pulse when set and clear edges coincide in IDLE
//   conflict_cnt out  saturating count of conflict pulses
//
// Build option
//   SR_CMD_CONFLICT_CNT_EN : when defined, conflict_cnt counts conflict pulses
//                            and saturates at 8'hFF (cleared only by rst).
//                            When undefined, conflict_cnt is tied to 8'h00 and
//                            no counter flops exist.
// -----------------------------------------------------------------------------
module sr_cmd_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_LEN       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       clr_btn,
  output logic       s,
  output logic       r,
  output logic       en,
  output logic       busy,
  output logic       conflict,
  output logic [7:0] conflict_cnt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);

  // Channel index 0 = set, 1 = clear.
  localparam int unsigned CH_SET = 0;
  localparam int unsigned CH_CLR = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SET  = 2'd1,
    ST_CLR  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser, debounce and edge-history registers
  // ---------------------------------------------------------------------------
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    db_q, db_d;
  logic [1:0]    db_prev_q;
  logic [CW-1:0] dcnt_q [2];
  logic [CW-1:0] dcnt_d [2];
  logic [1:0]    req;

  assign btn_raw = {clr_btn, set_btn};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dcnt_q[0] <= dcnt_d[0];
      dcnt_q[1] <= dcnt_d[1];
    end
  end

  // The counter runs only while the synced input disagrees with the accepted
  // state; any agreeing cycle restarts it, so a change must be stable for
  // DEBOUNCE_CYCLES consecutive cycles. Acceptance happens on the cycle the
  // count would reach DEBOUNCE_CYCLES, hence the compare against DB_LAST.
  always_comb begin
    db_d      = db_q;
    dcnt_d[0] = '0;
    dcnt_d[1] = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          db_d[i]   = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Rising edges of the debounced state only; releases produce nothing.
  assign req = db_q & ~db_prev_q;

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          conflict_q, conflict_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    conflict_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pcnt_d = '0;
        if (req[CH_SET] && req[CH_CLR]) begin
          conflict_d = 1'b1;
        end else if (req[CH_SET]) begin
          state_d = ST_SET;
        end else if (req[CH_CLR]) begin
          state_d = ST_CLR;
        end
      end
      ST_SET, ST_CLR: begin
        // Requests seen here are simply ignored; nothing is queued.
        if (pcnt_q == PULSE_LAST) begin
          state_d = ST_GAP;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
      end
    endcase

    // Outputs are registered copies decoded from the next state, so they
    // change on the same edge as the state itself and never glitch.
    s_d    = (state_d == ST_SET);
    r_d    = (state_d == ST_CLR);
    en_d   = s_d | r_d;
    busy_d = (state_d != ST_IDLE);
  end

  assign s        = s_q;
  assign r        = r_q;
  assign en       = en_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

  // ---------------------------------------------------------------------------
  // Optional conflict counter
  // ---------------------------------------------------------------------------
`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] ccnt_q, ccnt_d;

  always_comb begin
    ccnt_d = ccnt_q;
    if (conflict_d && (ccnt_q != 8'hFF)) begin
      ccnt_d = ccnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccnt_q <= '0;
    end else begin
      ccnt_q <= ccnt_d;
    end
  end

  assign conflict_cnt = ccnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_conditioner
//
// Directed bench for sr_cmd_conditioner with default parameters
// (DEBOUNCE_CYCLES=4, PULSE_LEN=2). Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point. "Edge n" is the n-th rising
// edge after the inputs were last changed.
// -----------------------------------------------------------------------------
module tb_sr_cmd_conditioner;

  logic       clk;
  logic       rst;
  logic       set_btn;
  logic       clr_btn;
  logic       s;
  logic       r;
  logic       en;
  logic       busy;
  logic       conflict;
  logic [7:0] conflict_cnt;

  int errors = 0;
  int checks = 0;

`ifdef SR_CMD_CONFLICT_CNT_EN
  localparam logic [7:0] CNT_ONE = 8'd1;
`else
  localparam logic [7:0] CNT_ONE = 8'd0;
`endif

  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_LEN      (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .set_btn     (set_btn),
    .clr_btn     (clr_btn),
    .s           (s),
    .r           (r),
    .en          (en),
    .busy        (busy),
    .conflict    (conflict),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // s, r, en, busy against expectations; en is always expected to be s|r.
  task automatic chk_out(input string tag, input logic es, input logic er, input logic eb);
    chk({tag, ".s"},    {7'd0, s},    {7'd0, es});
    chk({tag, ".r"},    {7'd0, r},    {7'd0, er});
    chk({tag, ".en"},   {7'd0, en},   {7'd0, es | er});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst     = 1'b0;
    set_btn = 1'b0;
    clr_btn = 1'b0;

    // Reset state, before any clock edge.
    #2;
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.conflict", {7'd0, conflict}, 8'd0);
    chk("rst.cnt", conflict_cnt, 8'd0);
    ticks(2);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: held set press -> s on edges 7..8, GAP on 9, idle from 10.
    set_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_out($sformatf("t1.e%0d", i), (i == 7 || i == 8), 1'b0, (i >= 7 && i <= 9));
    end
    set_btn = 1'b0;
    ticks(8);

    // 2: bouncing clear (1,0,1,0 then held); the held part starts at edge 5,
    //    so r is high on edges 11..12 only.
    for (int i = 1; i <= 16; i++) begin
      clr_btn = (i == 1 || i == 3 || i >= 5);
      tick();
      chk_out($sformatf("t2.e%0d", i), 1'b0, (i == 11 || i == 12), (i >= 11 && i <= 13));
    end
    clr_btn = 1'b0;
    ticks(8);

    // 3: set glitch of 3 cycles -> no command.
    for (int i = 1; i <= 12; i++) begin
      set_btn = (i <= 3);
      tick();
      chk_out($sformatf("t3.e%0d", i), 1'b0, 1'b0, 1'b0);
    end
    set_btn = 1'b0;
    ticks(4);

    // 4: simultaneous set and clear -> single conflict pulse on edge 7.
    set_btn = 1'b1;
    clr_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_out($sformatf("t4.e%0d", i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("t4.e%0d.conflict", i), {7'd0, conflict}, {7'd0, (i == 7)});
      chk($sformatf("t4.e%0d.cnt", i), conflict_cnt, (i >= 7) ? CNT_ONE : 8'd0);
    end
    set_btn = 1'b0;
    clr_btn = 1'b0;
    ticks(8);

    // 5: clear raised two edges after set; its request lands during SET and
    //    is dropped.
    for (int i = 1; i <= 14; i++) begin
      set_btn = 1'b1;
      clr_btn = (i >= 3);
      tick();
      chk_out($sformatf("t5.e%0d", i), (i == 7 || i == 8), 1'b0, (i >= 7 && i <= 9));
      chk($sformatf("t5.e%0d.conflict", i), {7'd0, conflict}, 8'd0);
    end
    set_btn = 1'b0;
    clr_btn = 1'b0;
    ticks(8);
    // Later clean clear press -> normal r pulse.
    clr_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_out($sformatf("t5b.e%0d", i), 1'b0, (i == 7 || i == 8), (i >= 7 && i <= 9));
    end
    clr_btn = 1'b0;
    ticks(8);

    // 6: reset during SET drops outputs without a clock edge; after release
    //    a held set is re-debounced and fires at the normal latency.
    set_btn = 1'b1;
    ticks(7);
    chk_out("t6.pre", 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_out("t6.async", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk_out($sformatf("t6.e%0d", i), (i == 7 || i == 8), 1'b0, (i >= 7 && i <= 9));
    end
    chk("t6.cnt_kept_cleared", conflict_cnt, 8'd0);
    set_btn = 1'b0;
    ticks(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
